// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one uart_tx serializer between N byte requesters
// The serializer has no busy output, so frame occupancy is tracked here with a frame-length counter.
module uart_tx_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int BIT_CLKS   = 5208,
  parameter int FRAME_BITS = 10,
  parameter int GAP_CLKS   = 2,
  parameter int CNT_W      = 17
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           ack,
  output logic                       tx_vld,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_idx
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(FRAME_BITS * BIT_CLKS + GAP_CLKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                tx_vld_q, tx_vld_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                busy_q, busy_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [DATA_W-1:0]   win_data;
  logic [IDX_W:0]      sum;
  logic [IDX_W-1:0]    cand;

  // Search ptr, ptr+1, ... with an explicit wrap so N_REQ need not be a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    sum       = '0;
    cand      = '0;
    for (int j = 0; j < N_REQ; j++) begin
      sum = {1'b0, ptr_q} + (IDX_W + 1)'(j);
      if (sum >= (IDX_W + 1)'(N_REQ)) begin
        sum = sum - (IDX_W + 1)'(N_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_data  = req_data[cand*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = '0;
    tx_vld_d    = 1'b0;
    tx_data_d   = tx_data_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d     = ST_SEND;
          grant_idx_d = win_idx;
          tx_data_d   = win_data;
          ack_d       = N_REQ'(1) << win_idx;
          tx_vld_d    = 1'b1;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
        ptr_d   = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ack_q       <= '0;
      tx_vld_q    <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      tx_vld_q    <= tx_vld_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ack       = ack_q;
  assign tx_vld    = tx_vld_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign grant_idx = grant_idx_q;

endmodule
